// File: rtl/pll_clkgen_multi_if.sv
// pll_clkgen_multi_if: valid/ready config port (chan, div, phase out; ready back) with master/slave modports
interface pll_clkgen_multi_if #(
  parameter int NUM_CLOCKS = 2,
  parameter int DIV_WIDTH  = 16
) ();
  localparam int CHAN_W = NUM_CLOCKS > 1 ? $clog2(NUM_CLOCKS) : 1;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAN_W-1:0]    cfg_chan;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] cfg_phase;
  modport master (output cfg_valid, cfg_chan, cfg_div, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/pll_clkgen_multi.sv
// pll_clkgen_multi: refclk-domain divided clocks with per-channel div/phase via cfg (slave), settle/lock model; outputs outclk, tick, locked
module pll_clkgen_multi #(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_WIDTH   = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DIV_INIT    = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_clkgen_multi_if.slave     cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);
  localparam int CHAN_W = NUM_CLOCKS > 1 ? $clog2(NUM_CLOCKS) : 1;
  localparam int CHAN_N = 2 ** CHAN_W;
  localparam int CNT_W  = $clog2(LOCK_CYCLES);
  localparam logic [CHAN_N-1:0] CHAN_OK = {CHAN_N{1'b1}} >> (CHAN_N - NUM_CLOCKS);
  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} state_t;
  state_t               state, state_nx;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 settle_done, apply, run;
  logic [DIV_WIDTH-1:0] new_div, new_phase;
  logic [DIV_WIDTH-1:0] div   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] phase [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] cnt   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] half  [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] armed;
  assign locked        = state == LOCKED;
  assign cfg.cfg_ready = locked;
  always_comb begin
    settle_done = settle_cnt == CNT_W'(LOCK_CYCLES - 1);
    apply       = locked && cfg.cfg_valid && CHAN_OK[cfg.cfg_chan];
    run         = locked && !apply;
    new_div     = cfg.cfg_div < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : cfg.cfg_div;
    new_phase   = cfg.cfg_phase >= new_div ? '0 : cfg.cfg_phase;
    state_nx    = state == SETTLE ? (settle_done ? LOCKED : SETTLE) : (apply ? SETTLE : LOCKED);
    for (int i = 0; i < NUM_CLOCKS; i++)
      half[i] = (div[i] >> 1) + DIV_WIDTH'(div[i][0]);
  end
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= (state == SETTLE && !settle_done) ? settle_cnt + 1'b1 : '0;
    end
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div[i]   <= DIV_WIDTH'(DIV_INIT);
        phase[i] <= '0;
        cnt[i]   <= '0;
      end
      armed  <= '0;
      outclk <= '0;
      tick   <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (apply && cfg.cfg_chan == CHAN_W'(i)) begin
          div[i]   <= new_div;
          phase[i] <= new_phase;
        end
        if (run) begin
          cnt[i]    <= cnt[i] == div[i] - 1'b1 ? '0 : cnt[i] + 1'b1;
          armed[i]  <= armed[i] | (cnt[i] == '0);
          outclk[i] <= cnt[i] < half[i] && (armed[i] || cnt[i] == '0);
          tick[i]   <= cnt[i] == '0;
        end else begin
          armed[i]  <= 1'b0;
          outclk[i] <= 1'b0;
          tick[i]   <= 1'b0;
          if (settle_done) cnt[i] <= phase[i] == '0 ? '0 : div[i] - phase[i];
        end
      end
    end
endmodule
